piso_serializer: RTL and testbench

//  Parallel-in/serial-out shifter: the transmit side of the serial-in/parallel-out capture registers.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/piso_serializer_bit_counter.sv | 36 +++
 rtl/piso_serializer.sv | 154 +++++++++++++++
 tb/tb_piso_serializer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift blocks (PISO transmit and SIPO capture).
// Holds the common FSM state encoding and a ceiling-log2 helper used to size
// bit counters from a word width.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int CLOG2(input int unsigned value);
        int r;
        r = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: index of the serial bit currently presented by the serializer.
// Counts 0..WIDTH-1 while enabled and wraps to 0 after the last index.
// Ports:
//   clk    rising-edge clock
//   clr    synchronous clear (count <= 0)
//   en     advance the count this cycle
//   count  current bit index, CLOG2(WIDTH) bits
//   last   count is at WIDTH-1
module bit_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      en,
    output logic [CLOG2(WIDTH)-1:0]   count,
    output logic                      last
);

    localparam int CW = CLOG2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    always_comb begin
        last = (count == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it one bit
// per clock on q with q_valid. Back-to-back words stream with no idle gap.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit
// (^word) after the data bits, making each frame WIDTH+1 cycles.
// Parameters:
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: din[WIDTH-1] sent first, 0: din[0] sent first
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   din         parallel word, sampled on accept
//   load_valid  producer offers a word
//   load_ready  serializer can take a word this cycle (combinational)
//   q           serial bit (registered)
//   q_valid     q carries a valid bit (registered)
//   busy        a word is in flight (registered)
//   done        pulse on the final bit of a frame (registered)
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = CLOG2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             last;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic             din_first;
    logic             sh_first;
    logic [WIDTH-1:0] din_rest;
    logic [WIDTH-1:0] sh_rest;

`ifdef PISO_PARITY_EN
    logic par;
`else
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);
`endif

    // The first bit of a word goes straight from din to q on the accept edge,
    // so the shift register only ever holds the bits still to be sent.
    always_comb begin
        din_first = (MSB_FIRST != 0) ? din[WIDTH-1]   : din[0];
        din_rest  = (MSB_FIRST != 0) ? (din << 1)     : (din >> 1);
        sh_first  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
        sh_rest   = (MSB_FIRST != 0) ? (shreg << 1)   : (shreg >> 1);
    end

    always_comb begin
        load_ready = 1'b0;
        if (rst_n) begin
`ifdef PISO_PARITY_EN
            load_ready = (state == ST_IDLE) || (state == ST_PARITY);
`else
            load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && last);
`endif
        end
        accept  = load_valid && load_ready;
        cnt_clr = !rst_n || (state == ST_IDLE);
        cnt_en  = (state == ST_SHIFT);
    end

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk   (clk),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PISO_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Load covers IDLE and the end-of-frame cycle alike; the
                // counter is already at 0 in both cases.
                state   <= ST_SHIFT;
                shreg   <= din_rest;
                q       <= din_first;
                q_valid <= 1'b1;
                busy    <= 1'b1;
`ifdef PISO_PARITY_EN
                par     <= din_first;
`endif
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (!last) begin
                            shreg <= sh_rest;
                            q     <= sh_first;
`ifdef PISO_PARITY_EN
                            par   <= par ^ sh_first;
`else
                            done  <= (count == PENULT_IDX);
`endif
                        end else begin
`ifdef PISO_PARITY_EN
                            state <= ST_PARITY;
                            q     <= par;
                            done  <= 1'b1;
`else
                            state   <= ST_IDLE;
                            q       <= 1'b0;
                            q_valid <= 1'b0;
                            busy    <= 1'b0;
`endif
                        end
                    end
`ifdef PISO_PARITY_EN
                    ST_PARITY: begin
                        state   <= ST_IDLE;
                        q       <= 1'b0;
                        q_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
`endif
                    default: begin
                        state   <= ST_IDLE;
                        q       <= 1'b0;
                        q_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// (WIDTH=8) sharing clock, reset and din. Build with PISO_PARITY_EN defined to
// exercise the parity frame.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       lv;
    logic       sel;
    logic       lv_a, lv_b;
    logic       ra, qa, qva, ba, da;
    logic       rb, qb, qvb, bb, db;
    logic       ready_s, q_s, qv_s, busy_s, done_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign lv_a    = lv & ~sel;
    assign lv_b    = lv & sel;
    assign ready_s = sel ? rb  : ra;
    assign q_s     = sel ? qb  : qa;
    assign qv_s    = sel ? qvb : qva;
    assign busy_s  = sel ? bb  : ba;
    assign done_s  = sel ? db  : da;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(lv_a), .load_ready(ra),
        .q(qa), .q_valid(qva), .busy(ba), .done(da)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(lv_b), .load_ready(rb),
        .q(qb), .q_valid(qvb), .busy(bb), .done(db)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // expbits lists the serial bits in transmit order, first bit at [7].
    task automatic send_word(input string tag, input logic [7:0] w,
                             input logic [7:0] expbits, input logic exppar);
        logic [7:0] rx;
        rx = '0;
        din = w;
        lv  = 1'b1;
        check({tag, ".ready"}, 32'(ready_s), 32'd1);
        tick;
        lv  = 1'b0;
        din = ~w;
        for (int k = 0; k < FL; k++) begin
            check($sformatf("%s.qv%0d", tag, k), 32'(qv_s), 32'd1);
            check($sformatf("%s.busy%0d", tag, k), 32'(busy_s), 32'd1);
            check($sformatf("%s.done%0d", tag, k), 32'(done_s), 32'(k == FL - 1));
            if (k < 8) begin
                check($sformatf("%s.q%0d", tag, k), 32'(q_s), 32'(expbits[7-k]));
                rx = sel ? {q_s, rx[7:1]} : {rx[6:0], q_s};
            end else begin
                check($sformatf("%s.par", tag), 32'(q_s), 32'(exppar));
            end
            tick;
        end
        check({tag, ".qv_end"}, 32'(qv_s), 32'd0);
        check({tag, ".busy_end"}, 32'(busy_s), 32'd0);
        check({tag, ".done_end"}, 32'(done_s), 32'd0);
        check({tag, ".q_end"}, 32'(q_s), 32'd0);
        check({tag, ".ready_end"}, 32'(ready_s), 32'd1);
        check({tag, ".sipo"}, 32'(rx), 32'(w));
    endtask

    initial begin
        logic [7:0] c3;
        sel   = 1'b0;
        lv    = 1'b0;
        din   = '0;
        rst_n = 1'b0;

        // Reset held for three clocks.
        repeat (3) tick;
        check("rst.q", 32'(qa), 32'd0);
        check("rst.qv", 32'(qva), 32'd0);
        check("rst.busy", 32'(ba), 32'd0);
        check("rst.done", 32'(da), 32'd0);
        check("rst.ready_a", 32'(ra), 32'd0);
        check("rst.ready_b", 32'(rb), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel.ready_a", 32'(ra), 32'd1);
        check("rel.ready_b", 32'(rb), 32'd1);

        // MSB-first A5: 1,0,1,0,0,1,0,1, parity 0.
        send_word("a5", 8'hA5, 8'hA5, 1'b0);

        // LSB-first: 01 -> 1,0,0,0,0,0,0,0 (parity 1); 0E -> 0,1,1,1,0,0,0,0 (parity 1).
        sel = 1'b1;
        send_word("l01", 8'h01, 8'h80, 1'b1);
        send_word("l0e", 8'h0E, 8'h70, 1'b1);
        sel = 1'b0;

        // Back-to-back FF then 00 with load_valid held.
        din = 8'hFF;
        lv  = 1'b1;
        tick;
        din = 8'h00;
        for (int k = 0; k < FL; k++) begin
            check($sformatf("b2b1.qv%0d", k), 32'(qva), 32'd1);
            check($sformatf("b2b1.q%0d", k), 32'(qa), 32'(k < 8));
            check($sformatf("b2b1.ready%0d", k), 32'(ra), 32'(k == FL - 1));
            tick;
        end
        lv = 1'b0;
        for (int k = 0; k < FL; k++) begin
            check($sformatf("b2b2.qv%0d", k), 32'(qva), 32'd1);
            check($sformatf("b2b2.q%0d", k), 32'(qa), 32'd0);
            check($sformatf("b2b2.ready%0d", k), 32'(ra), 32'(k == FL - 1));
            tick;
        end
        check("b2b.qv_end", 32'(qva), 32'd0);

        // Reset after three bits of C3 (1,1,0 sent).
        c3  = 8'hC3;
        din = c3;
        lv  = 1'b1;
        tick;
        lv  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid.q%0d", k), 32'(qa), 32'(c3[7-k]));
            tick;
        end
        rst_n = 1'b0;
        #1;
        check("mid.ready_in_rst", 32'(ra), 32'd0);
        tick;
        check("mid.qv", 32'(qva), 32'd0);
        check("mid.busy", 32'(ba), 32'd0);
        check("mid.q", 32'(qa), 32'd0);
        check("mid.done", 32'(da), 32'd0);
        rst_n = 1'b1;
        tick;
        check("mid.qv_idle", 32'(qva), 32'd0);
        send_word("3c", 8'h3C, 8'h3C, 1'b0);

        // 07: three ones, parity 1.
        send_word("07", 8'h07, 8'h07, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
